// File: rtl/mk8_reset_sequencer.sv
// Multi-domain reset sequencer: holds all domains in reset, then releases them one by one
// with a programmable gap. Optional watchdog retrigger is built when MK8_RST_SEQ_WDOG_EN is defined.
module mk8_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEF_HOLD    = 1000,
  parameter int unsigned DEF_GAP     = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic                   sw_reset_req,
  input  logic                   ext_req_n,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   busy
);

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CAUSE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       hold_q, hold_d, gap_q, gap_d;
  logic [NUM_DOMAINS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]       seq_hold_q, seq_hold_d, seq_gap_q, seq_gap_d;
  logic [NUM_DOMAINS-1:0] seq_mask_q, seq_mask_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;
  logic [1:0]             ext_sync_q;
  logic                   ext_prev_q, sw_prev_q;

  logic wr_en, wr_hold, wr_gap, wr_ctrl, wr_status, wr_wdog;
  logic sw_edge, ext_edge, ctrl_trig, wdog_trig, trig, seq_done;
  logic [CNT_W-1:0] hold_m1, gap_m1;
  logic [IDX_W-1:0] first_idx, next_idx;
  logic first_ok, next_ok;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  // Bus decode and trigger sources
  always_comb begin
    wr_en     = chipselect & ~write_n;
    wr_hold   = wr_en && (address == 3'd0);
    wr_gap    = wr_en && (address == 3'd1);
    wr_ctrl   = wr_en && (address == 3'd2);
    wr_status = wr_en && (address == 3'd3);
    wr_wdog   = wr_en && (address == 3'd4);
    sw_edge   = sw_reset_req & ~sw_prev_q;
    ext_edge  = ext_prev_q & ~ext_sync_q[1];
    ctrl_trig = wr_ctrl & writedata[0];
    trig      = sw_edge | ext_edge | ctrl_trig | wdog_trig;
    hold_m1   = (seq_hold_q == '0) ? '0 : seq_hold_q - CNT_W'(1);
    gap_m1    = (seq_gap_q == '0) ? '0 : seq_gap_q - CNT_W'(1);
  end

  // Lowest masked-in domain overall and lowest one above the current index
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    next_ok   = 1'b0;
    next_idx  = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (seq_mask_q[i]) begin
        first_ok  = 1'b1;
        first_idx = IDX_W'(i);
        if (i > int'(idx_q)) begin
          next_ok  = 1'b1;
          next_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_d      = rst_q;
    seq_hold_d = seq_hold_q;
    seq_gap_d  = seq_gap_q;
    seq_mask_d = seq_mask_q;
    seq_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          seq_hold_d = hold_q;
          seq_gap_d  = gap_q;
          seq_mask_d = mask_q;
          cnt_d      = '0;
          state_d    = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        rst_d = rst_q & ~seq_mask_q;
        if (trig) begin
          cnt_d = '0;
        end else if (cnt_q == hold_m1) begin
          cnt_d = '0;
          if (first_ok) begin
            state_d = ST_RELEASE;
            idx_d   = first_idx;
          end else begin
            state_d  = ST_IDLE;
            seq_done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        cnt_d = '0;
        if (trig) begin
          state_d = ST_ASSERT;
        end else begin
          rst_d = rst_q | (NUM_DOMAINS'(1) << idx_q);
          if (next_ok) begin
            state_d = ST_GAP;
            idx_d   = next_idx;
          end else begin
            state_d  = ST_IDLE;
            seq_done = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (trig) begin
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end else if (cnt_q == gap_m1) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Configuration registers; a same-cycle cause wins over its W1C
  always_comb begin
    hold_d  = wr_hold ? writedata[CNT_W-1:0] : hold_q;
    gap_d   = wr_gap ? writedata[CNT_W-1:0] : gap_q;
    mask_d  = wr_ctrl ? writedata[8 +: NUM_DOMAINS] : mask_q;
    cause_d = (cause_q & ~(wr_status ? writedata[CAUSE_W-1:0] : CAUSE_W'(0)))
            | {wdog_trig, ctrl_trig, ext_edge, sw_edge, 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_q      <= '0;
      busy_q     <= 1'b1;
      hold_q     <= CNT_W'(DEF_HOLD);
      gap_q      <= CNT_W'(DEF_GAP);
      mask_q     <= '1;
      seq_hold_q <= CNT_W'(DEF_HOLD);
      seq_gap_q  <= CNT_W'(DEF_GAP);
      seq_mask_q <= '1;
      cause_q    <= CAUSE_W'(1);
      ext_sync_q <= 2'b11;
      ext_prev_q <= 1'b1;
      sw_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_q      <= rst_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      mask_q     <= mask_d;
      seq_hold_q <= seq_hold_d;
      seq_gap_q  <= seq_gap_d;
      seq_mask_q <= seq_mask_d;
      cause_q    <= cause_d;
      ext_sync_q <= {ext_sync_q[0], ext_req_n};
      ext_prev_q <= ext_sync_q[1];
      sw_prev_q  <= sw_reset_req;
    end
  end

`ifdef MK8_RST_SEQ_WDOG_EN
  logic [CNT_W-1:0] wdog_to_q, wdog_to_d, wdog_cnt_q, wdog_cnt_d;

  // Down-counter reloads on any WDOG write and at the end of every sequence
  always_comb begin
    wdog_to_d  = wr_wdog ? writedata[CNT_W-1:0] : wdog_to_q;
    wdog_cnt_d = wdog_cnt_q;
    if (wr_wdog) begin
      wdog_cnt_d = writedata[CNT_W-1:0];
    end else if (seq_done) begin
      wdog_cnt_d = wdog_to_q;
    end else if ((wdog_to_q != '0) && (wdog_cnt_q != '0)) begin
      wdog_cnt_d = wdog_cnt_q - CNT_W'(1);
    end
    wdog_trig = (wdog_to_q != '0) && (wdog_cnt_q == '0) && (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_to_q  <= '0;
      wdog_cnt_q <= '0;
    end else begin
      wdog_to_q  <= wdog_to_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic unused_wdog;
  assign wdog_trig   = 1'b0;
  assign unused_wdog = seq_done | wr_wdog;
`endif

  // Zero-latency read mux
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[CNT_W-1:0] = hold_q;
      3'd1: readdata[CNT_W-1:0] = gap_q;
      3'd2: readdata[8 +: NUM_DOMAINS] = mask_q;
      3'd3: begin
        readdata[CAUSE_W-1:0] = cause_q;
        readdata[15:8]        = 8'(state_q);
        readdata[16]          = busy_q;
      end
`ifdef MK8_RST_SEQ_WDOG_EN
      3'd4: readdata[CNT_W-1:0] = wdog_to_q;
`endif
      default: readdata = '0;
    endcase
  end

  assign rst_out_n = rst_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mk8_reset_sequencer.sv
// Scoreboard bench for mk8_reset_sequencer: a timeline model predicts every rst_out_n change,
// a monitor pops and compares them as they appear; register/status readbacks are checked directly.
module tb_mk8_reset_sequencer;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          sw_reset_req;
  logic          ext_req_n;
  logic [N-1:0]  rst_out_n;
  logic          busy;

  mk8_reset_sequencer #(.NUM_DOMAINS(N), .CNT_W(16), .DEF_HOLD(1000), .DEF_GAP(100)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sw_reset_req(sw_reset_req), .ext_req_n(ext_req_n), .rst_out_n(rst_out_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) if (reset_n) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] val;
    bit           rise;
  } ev_t;

  ev_t          evq[$];
  logic [N-1:0] exp_cur = '0;
  bit           mon_en = 1'b0;

  int           m_hold = 1000;
  int           m_gap  = 100;
  logic [N-1:0] m_mask = '1;
  logic [4:0]   m_status = 5'b00001;
  int           seq_h, seq_g, last_rel = -1, last_t = 0;
  logic [N-1:0] seq_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Trigger seen by the sequencer at edge t: pending releases at/after t are pre-empted,
  // masked domains drop one edge later, then release in ascending order after hold and gaps.
  task automatic model_trigger(input int t, input logic [4:0] causes);
    ev_t keep[$];
    ev_t e;
    logic [N-1:0] v, nv;
    int c;
    m_status |= causes;
    last_t = t;
    if (t > last_rel) begin
      seq_h = (m_hold == 0) ? 1 : m_hold;
      seq_g = (m_gap == 0) ? 1 : m_gap;
      seq_m = m_mask;
    end
    foreach (evq[i]) if (!(evq[i].rise && evq[i].cyc >= t)) keep.push_back(evq[i]);
    evq = keep;
    v = exp_cur;
    foreach (evq[i]) v = evq[i].val;
    nv = v & ~seq_m;
    if (nv != v) begin
      e.cyc = t + 1; e.val = nv; e.rise = 1'b0;
      evq.push_back(e);
    end
    c = t + 1 + seq_h;
    for (int i = 0; i < N; i++) begin
      if (seq_m[i]) begin
        nv[i] = 1'b1;
        e.cyc = c; e.val = nv; e.rise = 1'b1;
        evq.push_back(e);
        last_rel = c;
        c += seq_g + 1;
      end
    end
  endtask

  // Monitor: every change of rst_out_n must match the head of the expected queue
  initial begin
    logic [N-1:0] last_obs = '0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst_out_n !== last_obs) begin
          checks++;
          if (evq.size() == 0) begin
            errors++;
            $display("FAIL rst_event: unexpected rst_out_n=%b at cycle %0d", rst_out_n, cyc);
          end else begin
            e = evq.pop_front();
            exp_cur = e.val;
            if (cyc != e.cyc || rst_out_n !== e.val) begin
              errors++;
              $display("FAIL rst_event: got rst_out_n=%b at cycle %0d, required %b at cycle %0d",
                       rst_out_n, cyc, e.val, e.cyc);
            end
          end
          last_obs = rst_out_n;
        end else if (evq.size() > 0 && evq[0].cyc < cyc) begin
          checks++;
          errors++;
          e = evq.pop_front();
          exp_cur = e.val;
          $display("FAIL rst_event: rst_out_n stayed %b, required %b at cycle %0d",
                   rst_out_n, e.val, e.cyc);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    case (a)
      3'd0: m_hold = int'(d[15:0]);
      3'd1: m_gap = int'(d[15:0]);
      3'd2: m_mask = d[8 +: N];
      3'd3: m_status &= ~d[4:0];
      default: ;
    endcase
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic chk_status(input string name, input bit bsy, input logic [7:0] st);
    logic [31:0] d;
    rd(3'd3, d);
    chk(name, d, {15'd0, bsy, st, 3'd0, m_status});
  endtask

  // Fire triggers from one negedge; sw/CTRL act at the next edge, ext three edges later
  task automatic fire(input bit f_sw, input bit f_ctrl, input bit f_ext, input bit f_w1c);
    int k;
    @(negedge clk);
    k = cyc;
    if (f_sw) sw_reset_req = 1'b1;
    if (f_ext) ext_req_n = 1'b0;
    if (f_ctrl || f_w1c) begin
      chipselect = 1'b1; write_n = 1'b0;
      address   = f_ctrl ? 3'd2 : 3'd3;
      writedata = f_ctrl ? (32'd1 | (32'(m_mask) << 8)) : 32'h1F;
    end
    if (f_w1c) m_status = 5'b0;
    if (f_sw || f_ctrl) model_trigger(k + 1, {1'b0, f_ctrl, 1'b0, f_sw, 1'b0});
    if (f_ext) model_trigger(k + 3, 5'b00100);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; sw_reset_req = 1'b0;
    if (f_ext) begin
      @(negedge clk);
      ext_req_n = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((evq.size() > 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, required idle", name, busy, evq.size(), n);
    end
    repeat (2) @(negedge clk);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk_status({name, "_status"}, 1'b0, 8'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int h, g, sel, t0, k;
    logic [N-1:0] m;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    sw_reset_req = 1'b0; ext_req_n = 1'b1;
    model_trigger(0, 5'b0);
    repeat (3) @(negedge clk);

    chk("reset_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    rd(3'd0, d); chk("reset_hold", d, 32'd1000);
    rd(3'd1, d); chk("reset_gap", d, 32'd100);
    rd(3'd2, d); chk("reset_ctrl", d, 32'h0000_0F00);
    chk_status("reset_status", 1'b1, 8'd1);

    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_idle("por");
    wr(3'd3, 32'h1);

    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, d); chk("unmapped5", d, 32'd0);
    rd(3'd7, d); chk("unmapped7", d, 32'd0);
`ifndef MK8_RST_SEQ_WDOG_EN
    wr(3'd4, 32'd50);
    rd(3'd4, d); chk("wdog_absent", d, 32'd0);
`endif

    // Masked sequence with a HOLD write mid-sequence that must not affect it
    wr(3'd0, 32'd5); wr(3'd1, 32'd2); wr(3'd2, 32'h0000_0500);
    rd(3'd2, d); chk("ctrl_mask_rb", d, 32'h0000_0500);
    fire(1'b1, 1'b0, 1'b0, 1'b0);
    chk("seq_busy", 32'(busy), 32'd1);
    wr(3'd0, 32'd9);
    wait_idle("masked_sw");
    rd(3'd0, d); chk("hold_rb", d, 32'd9);
    wr(3'd3, 32'h1F);

    // External request during the gap after domain 1 releases
    wr(3'd0, 32'd5); wr(3'd1, 32'd4); wr(3'd2, 32'h0000_0F00);
    fire(1'b1, 1'b0, 1'b0, 1'b0);
    t0 = last_t;
    while (cyc < t0 + 9) @(negedge clk);
    fire(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ext_reassert", 32'(rst_out_n), 32'd0);
    chk_status("ext_restart_status", 1'b1, 8'd1);
    wait_idle("ext_gap");
    wr(3'd3, 32'h1F);

    // CTRL trigger and sw edge in the same cycle start a single sequence
    fire(1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle("sw_ctrl");
    wr(3'd3, 32'h1F);

    // W1C of all causes concurrent with a new sw cause
    fire(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("ext_only");
    fire(1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle("w1c_race");
    wr(3'd3, 32'h1F);

    for (int it = 0; it < 12; it++) begin
      h   = $urandom_range(0, 8);
      g   = $urandom_range(0, 4);
      m   = N'($urandom_range(1, 15));
      wr(3'd0, 32'(h)); wr(3'd1, 32'(g)); wr(3'd2, 32'(m) << 8);
      sel = $urandom_range(0, 2);
      fire(sel == 0, sel == 1, sel == 2, 1'b0);
      if ($urandom_range(0, 1) == 1) wr(3'd0, 32'($urandom_range(0, 8)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        sel = $urandom_range(0, 1);
        fire(sel == 0, 1'b0, sel == 1, 1'b0);
      end
      wait_idle("random");
      wr(3'd3, 32'h1F);
    end

`ifdef MK8_RST_SEQ_WDOG_EN
    wr(3'd0, 32'd3); wr(3'd1, 32'd1); wr(3'd2, 32'h0000_0F00);
    @(negedge clk);
    k = cyc;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'd50;
    model_trigger(k + 52, 5'b10000);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(3'd4, d); chk("wdog_rb", d, 32'd50);
    while (cyc < k + 53) @(negedge clk);
    wr(3'd4, 32'd0);
    wait_idle("wdog");
`endif

    chk("evq_empty", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
